// File: rtl/payload_engine_gap.sv
// payload_engine_gap: prefix / bounded-gap / suffix payload matcher.
// Runs an exact NFA over pre-decoded class lines, one byte per enabled cycle,
// and latches a sticky match flag plus the 1-based offset of the first match.
module payload_engine_gap #(
  parameter int                   N_CLASS   = 32,
  parameter int                   PRE_LEN   = 4,
  parameter logic [8*PRE_LEN-1:0] PRE_SEL   = {8'd3, 8'd17, 8'd32, 8'd1},
  parameter int                   SUF_LEN   = 3,
  parameter logic [8*SUF_LEN-1:0] SUF_SEL   = {8'd4, 8'd16, 8'd6},
  parameter int                   GAP_CLASS = 0,
  parameter int                   GAP_MIN   = 0,
  parameter int                   GAP_MAX   = 8,
  parameter int                   ANCHOR    = 0,
  parameter int                   CNT_W     = 16
) (
  input  logic               clk,
  input  logic               sod,
  input  logic               en,
  input  logic [N_CLASS-1:0] in_class,
  output logic               out,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_offset,
  output logic [CNT_W-1:0]   byte_cnt
);

  // Class lookup; an index beyond the decoded lines reads as "no match".
  function automatic logic cls(input logic [N_CLASS-1:0] lines, input logic [7:0] idx);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N_CLASS; k++) begin
      if (idx == 8'(k)) hit = lines[k];
    end
    return hit;
  endfunction

  logic [PRE_LEN-1:0] p_q, p_n;     // p_q[i] holds prefix position i+1
  logic [GAP_MAX:0]   g_q, g_n;     // bit 0 is never stored; it aliases the last prefix bit
  logic [GAP_MAX:0]   g_all;
  logic [SUF_LEN-1:0] s_q, s_n;     // s_q[k] holds suffix position k+1
  logic               p0;
  logic               gap_hit;
  logic [CNT_W-1:0]   cnt_n;

  // Next-state of every NFA position, the gap window OR and the saturating count.
  always_comb begin
    p0      = (ANCHOR != 0) ? (byte_cnt == '0) : 1'b1;
    p_n     = '0;
    g_n     = '0;
    s_n     = '0;
    gap_hit = 1'b0;
    g_all    = g_q;
    g_all[0] = p_q[PRE_LEN-1];

    p_n[0] = cls(in_class, PRE_SEL[7:0]) & p0;
    for (int i = 1; i < PRE_LEN; i++) begin
      p_n[i] = cls(in_class, PRE_SEL[8*i +: 8]) & p_q[i-1];
    end

    for (int j = 1; j <= GAP_MAX; j++) begin
      g_n[j] = cls(in_class, 8'(GAP_CLASS)) & g_all[j-1];
    end

    for (int j = GAP_MIN; j <= GAP_MAX; j++) begin
      gap_hit = gap_hit | g_all[j];
    end

    s_n[0] = cls(in_class, SUF_SEL[7:0]) & gap_hit;
    for (int k = 1; k < SUF_LEN; k++) begin
      s_n[k] = cls(in_class, SUF_SEL[8*k +: 8]) & s_q[k-1];
    end

    cnt_n = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;
  end

  // NFA state and byte counter: cleared by sod, advanced on each consumed byte.
  always_ff @(posedge clk) begin
    if (sod) begin
      p_q      <= '0;
      g_q      <= '0;
      s_q      <= '0;
      byte_cnt <= '0;
    end else if (en) begin
      p_q      <= p_n;
      g_q      <= g_n;
      s_q      <= s_n;
      byte_cnt <= cnt_n;
    end
  end

  // Match reporting: only the first completed suffix since sod is recorded.
  always_ff @(posedge clk) begin
    if (sod) begin
      out          <= 1'b0;
      match_pulse  <= 1'b0;
      match_offset <= '0;
    end else if (en && s_n[SUF_LEN-1] && !out) begin
      out          <= 1'b1;
      match_pulse  <= 1'b1;
      match_offset <= cnt_n;
    end else begin
      match_pulse  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_payload_engine_gap.sv
// Bench for payload_engine_gap: three instances share one byte stream
// (unanchored, anchored, 4-bit counter) and are checked against a
// string-level reference that searches the stored packet for "ab x{1,3} cd".
module tb_payload_engine_gap;

  logic        clk = 1'b0;
  logic        sod;
  logic        en;
  logic [7:0]  in_class;

  logic        out0, out1, out2;
  logic        pulse0, pulse1, pulse2;
  logic [15:0] off0, off1, cnt0, cnt1;
  logic [3:0]  off2, cnt2;

  always #5 clk = ~clk;

  // class lines: 1=a 2=b 3=c 4=d 5=x 6=z 7=anything else
  payload_engine_gap #(.N_CLASS(8), .PRE_LEN(2), .PRE_SEL({8'd2, 8'd1}), .SUF_LEN(2),
    .SUF_SEL({8'd4, 8'd3}), .GAP_CLASS(5), .GAP_MIN(1), .GAP_MAX(3), .ANCHOR(0), .CNT_W(16))
  u0 (.clk(clk), .sod(sod), .en(en), .in_class(in_class), .out(out0),
      .match_pulse(pulse0), .match_offset(off0), .byte_cnt(cnt0));

  payload_engine_gap #(.N_CLASS(8), .PRE_LEN(2), .PRE_SEL({8'd2, 8'd1}), .SUF_LEN(2),
    .SUF_SEL({8'd4, 8'd3}), .GAP_CLASS(5), .GAP_MIN(1), .GAP_MAX(3), .ANCHOR(1), .CNT_W(16))
  u1 (.clk(clk), .sod(sod), .en(en), .in_class(in_class), .out(out1),
      .match_pulse(pulse1), .match_offset(off1), .byte_cnt(cnt1));

  payload_engine_gap #(.N_CLASS(8), .PRE_LEN(2), .PRE_SEL({8'd2, 8'd1}), .SUF_LEN(2),
    .SUF_SEL({8'd4, 8'd3}), .GAP_CLASS(5), .GAP_MIN(1), .GAP_MAX(3), .ANCHOR(0), .CNT_W(4))
  u2 (.clk(clk), .sod(sod), .en(en), .in_class(in_class), .out(out2),
      .match_pulse(pulse2), .match_offset(off2), .byte_cnt(cnt2));

  int errors = 0;
  int checks = 0;
  int pulses0 = 0;

  // reference state
  byte q[$];
  bit  m_out[3];
  bit  m_pulse[3];
  int  m_off[3];
  int  m_cnt[3];
  int  cmax[3] = '{65535, 65535, 15};
  bit  anch[3] = '{1'b0, 1'b1, 1'b0};

  typedef struct {
    string s;
    bit    e0;
    int    o0;
    bit    e1;
    int    o1;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cls_of(input byte ch);
    case (ch)
      "a":     return 8'b0000_0010;
      "b":     return 8'b0000_0100;
      "c":     return 8'b0000_1000;
      "d":     return 8'b0001_0000;
      "x":     return 8'b0010_0000;
      "z":     return 8'b0100_0000;
      default: return 8'b1000_0000;
    endcase
  endfunction

  // does some "ab" x{1..3} "cd" end at the last byte of the packet?
  function automatic bit match_ends(input bit anchored);
    int n;
    int st;
    bit ok;
    n = q.size();
    for (int gl = 1; gl <= 3; gl++) begin
      st = n - (gl + 4);
      if (st < 0) continue;
      if (anchored && st != 0) continue;
      ok = (q[st] == "a") && (q[st+1] == "b");
      for (int t = 0; t < gl; t++) ok = ok && (q[st+2+t] == "x");
      ok = ok && (q[n-2] == "c") && (q[n-1] == "d");
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_update(input bit s, input bit e, input byte ch);
    if (s) begin
      q.delete();
      for (int k = 0; k < 3; k++) begin
        m_out[k] = 0; m_pulse[k] = 0; m_off[k] = 0; m_cnt[k] = 0;
      end
    end else if (e) begin
      q.push_back(ch);
      for (int k = 0; k < 3; k++) begin
        if (m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (!m_out[k] && match_ends(anch[k])) begin
          m_out[k] = 1; m_pulse[k] = 1; m_off[k] = m_cnt[k];
        end else begin
          m_pulse[k] = 0;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) m_pulse[k] = 0;
    end
  endtask

  task automatic step(input bit s, input bit e, input byte ch);
    @(negedge clk);
    sod = s; en = e; in_class = cls_of(ch);
    @(posedge clk);
    model_update(s, e, ch);
    #1;
    if (pulse0 === 1'b1) pulses0++;
    chk("out0", 32'(out0), 32'(m_out[0]));     chk("pulse0", 32'(pulse0), 32'(m_pulse[0]));
    chk("offset0", 32'(off0), m_off[0]);       chk("byte_cnt0", 32'(cnt0), m_cnt[0]);
    chk("out1", 32'(out1), 32'(m_out[1]));     chk("pulse1", 32'(pulse1), 32'(m_pulse[1]));
    chk("offset1", 32'(off1), m_off[1]);       chk("byte_cnt1", 32'(cnt1), m_cnt[1]);
    chk("out2", 32'(out2), 32'(m_out[2]));     chk("pulse2", 32'(pulse2), 32'(m_pulse[2]));
    chk("offset2", 32'(off2), m_off[2]);       chk("byte_cnt2", 32'(cnt2), m_cnt[2]);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i]);
  endtask

  task automatic restart();
    step(1'b1, 1'b0, "z");
    pulses0 = 0;
  endtask

  initial begin
    string alph;
    string w;
    int    n;

    vt[0] = '{"abxcd",     1'b1, 5, 1'b1, 5};
    vt[1] = '{"abcd",      1'b0, 0, 1'b0, 0};
    vt[2] = '{"abxxxcd",   1'b1, 7, 1'b1, 7};
    vt[3] = '{"abxxxxcd",  1'b0, 0, 1'b0, 0};
    vt[4] = '{"aabxcd",    1'b1, 6, 1'b0, 0};
    vt[5] = '{"abxabxxcd", 1'b1, 9, 1'b0, 0};
    vt[6] = '{"zabxcd",    1'b1, 6, 1'b0, 0};

    sod = 1'b1; en = 1'b0; in_class = '0;

    // reset state
    restart();
    chk("rst_out", 32'(out0), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_offset", 32'(off0), 0);

    // table-driven patterns
    foreach (vt[i]) begin
      restart();
      send(vt[i].s);
      chk({"tbl_out0 ", vt[i].s}, 32'(out0), 32'(vt[i].e0));
      chk({"tbl_off0 ", vt[i].s}, 32'(off0), vt[i].o0);
      chk({"tbl_pulses ", vt[i].s}, pulses0, vt[i].e0 ? 1 : 0);
      chk({"tbl_out1 ", vt[i].s}, 32'(out1), 32'(vt[i].e1));
      chk({"tbl_off1 ", vt[i].s}, 32'(off1), vt[i].o1);
    end

    // en low between every byte; then a second match keeps the first offset
    restart();
    alph = "abxcd";
    for (int i = 0; i < alph.len(); i++) begin
      step(1'b0, 1'b1, alph[i]);
      step(1'b0, 1'b0, "z");
      step(1'b0, 1'b0, "a");
    end
    chk("idle_out", 32'(out0), 1);
    chk("idle_off", 32'(off0), 5);
    chk("idle_pulses", pulses0, 1);
    send("abxcd");
    chk("second_out", 32'(out0), 1);
    chk("second_off", 32'(off0), 5);
    chk("second_pulses", pulses0, 1);

    // sod mid-packet
    restart();
    send("abx");
    step(1'b1, 1'b0, "z");
    send("cd");
    chk("midsod_out", 32'(out0), 0);
    chk("midsod_cnt", 32'(cnt0), 2);

    // sod coincides with the completing byte, then anchored seed after sod
    restart();
    send("abxc");
    step(1'b1, 1'b1, "d");
    chk("sodcomp_out", 32'(out0), 0);
    chk("sodcomp_cnt", 32'(cnt0), 0);
    send("abxcd");
    chk("anchor_out", 32'(out1), 1);
    chk("anchor_off", 32'(off1), 5);

    // counter saturation on the 4-bit instance
    restart();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, "z");
    send("abxcd");
    chk("sat_cnt", 32'(cnt2), 15);
    chk("sat_off", 32'(off2), 15);
    chk("sat_out", 32'(out2), 1);
    chk("wide_off", 32'(off0), 25);

    // randomized near-miss and hit words with random idles and sod
    alph = "abcdxz";
    restart();
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 9) == 0) step(1'b1, $urandom_range(0, 1) == 1, "a");
      w = "";
      n = $urandom_range(0, 3);
      for (int t = 0; t < n; t++) w = {w, string'(alph[$urandom_range(0, 5)])};
      if ($urandom_range(0, 3) == 0) w = {w, "a"};
      w = {w, "ab"};
      n = $urandom_range(0, 4);
      for (int t = 0; t < n; t++) w = {w, ($urandom_range(0, 7) == 0) ? "a" : "x"};
      w = {w, ($urandom_range(0, 4) == 0) ? "x" : "c"};
      w = {w, ($urandom_range(0, 4) == 0) ? "z" : "d"};
      for (int i = 0; i < w.len(); i++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, alph[$urandom_range(0, 5)]);
        step(1'b0, 1'b1, w[i]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
